mdu_unit: RTL

Multi-cycle multiply/divide unit in the execute stage, downstream of the ALU operand-B select. It takes operand A (rs data) and the selected operand B and runs MIPS mult/multu/div/divu over a fixed number of cycles. It holds the HI/LO architectural registers and supports mthi/mtlo writes. It exposes `busy` so hazard control can stall mfhi/mflo and further MD instructions.

---
 rtl/mdu_unit.sv | 80 ++++++++
 1 files changed

// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle MIPS mult/multu/div/divu with HI/LO and mthi/mtlo; divider built only with MDU_DIV_EN.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] oprand_a,
  input  logic [31:0] aluoprand_b,
  input  logic [2:0]  mdop,
  input  logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  logic [CW-1:0] cnt, cnt_d;
  logic [31:0] a_q, b_q, a_d, b_d, hi_q, lo_q, hi_d, lo_d;
  logic        sgn_q, sgn_d, dv_q, dv_d;
  logic        accept, is_mul, is_div, launch, wr;
  logic [63:0] mul_s, mul_u, res;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sgn_q <= 1'b0;
      dv_q  <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      cnt   <= cnt_d;
      a_q   <= a_d;
      b_q   <= b_d;
      sgn_q <= sgn_d;
      dv_q  <= dv_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
`ifdef MDU_DIV_EN
  logic        div_zero, ovf;
  logic [31:0] b_nz, q_s, r_s, q_u, r_u;
  always_comb begin
    div_zero = b_q == '0;
    b_nz     = div_zero ? 32'd1 : b_q;
    ovf      = a_q == 32'h8000_0000 && b_q == 32'hffff_ffff;
    q_s      = ovf ? 32'h8000_0000 : 32'($signed(a_q) / $signed(b_nz));
    r_s      = ovf ? 32'd0 : 32'($signed(a_q) % $signed(b_nz));
    q_u      = a_q / b_nz;
    r_u      = a_q % b_nz;
  end
  assign is_div = mdop == 3'd3 || mdop == 3'd4;
  assign dv_d   = launch ? is_div : dv_q;
  assign res    = !dv_q ? (sgn_q ? mul_s : mul_u) : sgn_q ? {r_s, q_s} : {r_u, q_u};
  // A zero divisor still burns the full latency but leaves HI/LO intact.
  assign wr     = cnt == CW'(1) && !(dv_q && div_zero);
`else
  assign is_div = 1'b0;
  assign dv_d   = 1'b0;
  assign res    = sgn_q ? mul_s : mul_u;
  assign wr     = cnt == CW'(1) && !dv_q;
`endif
  always_comb begin
    accept = start && cnt == '0;
    is_mul = mdop == 3'd1 || mdop == 3'd2;
    launch = accept && (is_mul || is_div);
    cnt_d  = launch ? (is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES)) : cnt != '0 ? cnt - CW'(1) : cnt;
    a_d    = launch ? oprand_a : a_q;
    b_d    = launch ? aluoprand_b : b_q;
    sgn_d  = launch ? (mdop == 3'd1 || mdop == 3'd3) : sgn_q;
    mul_s  = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    mul_u  = {32'd0, a_q} * {32'd0, b_q};
    hi_d   = wr ? res[63:32] : accept && mdop == 3'd5 ? oprand_a : hi_q;
    lo_d   = wr ? res[31:0] : accept && mdop == 3'd6 ? oprand_a : lo_q;
  end
  assign busy = cnt != '0;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule
